booth_mult_seq: RTL and testbench



---
 rtl/booth_mult_seq_if.sv | 39 +++
 rtl/booth_mult_seq.sv | 115 +++++++++++
 tb/tb_booth_mult_seq.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_seq_if.sv
// Stream interface for the sequential Booth multiplier: operand handshake in, product handshake out.
// The multiplier drives the slave modport; the upstream/downstream stage uses master.
interface booth_mult_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output signed_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  signed_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product,
        output busy
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Radix-4 Booth multiplier, signed/unsigned per transaction, one Booth digit retired per clock.
// Latency WIDTH/2+1 cycles after accept; in_ready low until the product is taken, result held under backpressure.
module booth_mult_seq #(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    booth_mult_seq_if.slave  bus
);
    localparam int AW = 2 * WIDTH + 2;
    localparam int EW = WIDTH + 2;
    localparam int BW = WIDTH + 3;
    localparam int N  = WIDTH / 2 + 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 4 || OUT_WIDTH != 2 * WIDTH) begin : g_bad_param
        $error("booth_mult_seq: WIDTH must be even and >= 4, OUT_WIDTH must equal 2*WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [AW-1:0]         mcand_q, mcand_d;
    logic [BW-1:0]         booth_q, booth_d;
    logic [CW-1:0]         step_q, step_d;
    logic [2*WIDTH-1:0]    product_q, product_d;

    logic [EW-1:0]         a_ext;
    logic [EW-1:0]         b_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            booth_q   <= '0;
            step_q    <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            booth_q   <= booth_d;
            step_q    <= step_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        booth_d   = booth_q;
        step_d    = step_q;
        product_d = product_q;
        a_ext     = '0;
        b_ext     = '0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Two guard bits let the unsigned top Booth digit see a zero sign.
                    a_ext   = bus.signed_mode ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
                    b_ext   = bus.signed_mode ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};
                    mcand_d = {{(AW - EW){a_ext[EW-1]}}, a_ext};
                    booth_d = {b_ext, 1'b0};
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = CALC;
                end
            end

            CALC: begin
                case (booth_q[2:0])
                    3'b001, 3'b010: acc_d = acc_q + mcand_q;
                    3'b011:         acc_d = acc_q + {mcand_q[AW-2:0], 1'b0};
                    3'b100:         acc_d = acc_q - {mcand_q[AW-2:0], 1'b0};
                    3'b101, 3'b110: acc_d = acc_q - mcand_q;
                    default:        acc_d = acc_q;
                endcase
                // Multiplicand pre-shifted each step so it always carries weight 4^step.
                mcand_d = {mcand_q[AW-3:0], 2'b00};
                booth_d = {{2{booth_q[BW-1]}}, booth_q[BW-1:2]};
                step_d  = step_q + CW'(1);
                if (step_q == LAST_STEP) begin
                    product_d = acc_d[2*WIDTH-1:0];
                    state_d   = DONE;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.product   = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and model-based checks of booth_mult_seq at WIDTH=8.
module tb_booth_mult_seq;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    booth_mult_seq_if #(.WIDTH(W)) bus ();

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one transaction and waits for out_valid; lat counts edges after the accept edge.
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic sm,
                          input logic rdy, output logic [2*W-1:0] p, output int lat,
                          output logic timed_out);
        int guard;
        timed_out = 1'b0;
        @(posedge clk); #1;
        bus.in_valid    = 1'b1;
        bus.a           = ai;
        bus.b           = bi;
        bus.signed_mode = sm;
        bus.out_ready   = rdy;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (guard >= 100 || lat >= 100) timed_out = 1'b1;
        p = bus.product;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.product !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b product=%h, required 1 0 0 0000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.product);
        end
    endtask

    task automatic test_unsigned_max();
        logic [2*W-1:0] p;
        int lat;
        logic to;
        int saw_ready;
        saw_ready = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.signed_mode = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) saw_ready++;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.in_ready) saw_ready++;
        p = bus.product;
        n_checks++;
        if (p !== 16'hFE01) begin
            n_fail++;
            $display("FAIL unsigned_max_product: got %h, required FE01", p);
        end
        n_checks++;
        if (lat != 5) begin
            n_fail++;
            $display("FAIL unsigned_max_latency: got %0d cycles, required 5", lat);
        end
        n_checks++;
        if (saw_ready != 0) begin
            n_fail++;
            $display("FAIL in_ready_low_when_busy: in_ready high in %0d busy cycles, required 0", saw_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL return_to_idle: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
        to = 1'b0;
        if (to) n_fail++;
    endtask

    task automatic test_signed_vectors();
        logic [W-1:0]   va [3];
        logic [W-1:0]   vb [3];
        logic [2*W-1:0] ve [3];
        logic [2*W-1:0] p;
        int lat;
        logic to;
        va[0] = 8'h80; vb[0] = 8'h80; ve[0] = 16'h4000;
        va[1] = 8'hFD; vb[1] = 8'h05; ve[1] = 16'hFFF1;
        va[2] = 8'h7F; vb[2] = 8'h80; ve[2] = 16'hC080;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b1, 1'b1, p, lat, to);
            n_checks++;
            if (to || p !== ve[i]) begin
                n_fail++;
                $display("FAIL signed_vec%0d: %h*%h got %h (timeout=%b), required %h",
                         i, va[i], vb[i], p, to, ve[i]);
            end
        end
    endtask

    task automatic test_mode_select();
        logic [2*W-1:0] p;
        int lat;
        logic to;
        run_op(8'hFF, 8'h02, 1'b0, 1'b1, p, lat, to);
        n_checks++;
        if (to || p !== 16'h01FE) begin
            n_fail++;
            $display("FAIL mode_unsigned: got %h (timeout=%b), required 01FE", p, to);
        end
        run_op(8'hFF, 8'h02, 1'b1, 1'b1, p, lat, to);
        n_checks++;
        if (to || p !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL mode_signed: got %h (timeout=%b), required FFFE", p, to);
        end
    endtask

    task automatic test_backpressure();
        logic [2*W-1:0] p;
        int lat;
        logic to;
        int bad;
        run_op(8'd12, 8'd11, 1'b0, 1'b0, p, lat, to);
        n_checks++;
        if (to || p !== 16'd132) begin
            n_fail++;
            $display("FAIL bp_product: got %h (timeout=%b), required 0084", p, to);
        end
        bus.in_valid = 1'b1; bus.a = 8'd3; bus.b = 8'd3;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.product !== 16'd132) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
        run_op(8'd20, 8'd13, 1'b0, 1'b1, p, lat, to);
        n_checks++;
        if (to || p !== 16'd260) begin
            n_fail++;
            $display("FAIL bp_next_op: got %h (timeout=%b), required 0104", p, to);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [2*W-1:0] p;
        int lat;
        logic to;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.a = 8'd100; bus.b = 8'd50; bus.signed_mode = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.product !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid_op: in_ready=%b out_valid=%b busy=%b product=%h, required 1 0 0 0000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd7, 8'd9, 1'b0, 1'b1, p, lat, to);
        n_checks++;
        if (to || p !== 16'd63) begin
            n_fail++;
            $display("FAIL after_reset_op: got %h (timeout=%b), required 003F", p, to);
        end
    endtask

    task automatic test_random();
        logic [W-1:0]   ai, bi;
        logic           sm;
        logic [2*W-1:0] p, exp_p;
        logic signed [2*W-1:0] sprod;
        int lat;
        logic to;
        int stall;
        int bad;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            ai = W'($urandom);
            bi = W'($urandom);
            sm = 1'($urandom);
            if (sm) begin
                sprod = $signed(ai) * $signed(bi);
                exp_p = sprod;
            end else begin
                exp_p = {8'h00, ai} * {8'h00, bi};
            end
            run_op(ai, bi, sm, 1'b0, p, lat, to);
            if (to || p !== exp_p || lat != 5) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL random%0d: %h*%h sm=%b got %h lat=%0d, required %h lat=5",
                             i, ai, bi, sm, p, lat, exp_p);
            end
            stall = $urandom_range(0, 3);
            for (int k = 0; k < stall; k++) begin
                @(posedge clk); #1;
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL random_regression: %0d bad results, required 0", bad);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        bus.in_valid    = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.signed_mode = 1'b0;
        bus.out_ready   = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_unsigned_max();
        test_signed_vectors();
        test_mode_select();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
